ifu_prefetch_queue: RTL



---
 rtl/ifu_prefetch_queue_if.sv | 43 ++++
 rtl/ifu_prefetch_queue.sv | 108 ++++++++++
 2 files changed

// File: rtl/ifu_prefetch_queue_if.sv
// rtl/ifu_prefetch_queue_if.sv - fetch unit bus bundle: redirect, memory request/response, instruction output
//
// Purpose: groups every handshake/bus signal of ifu_prefetch_queue.
//   master : the fetch unit (drives mem_req_*, inst_*)
//   slave  : its environment (pipeline redirect, memory, decode stage)
// Signals:
//   redirect_valid/redirect_pc        flush and restart fetch
//   mem_req_valid/ready/addr          fetch request handshake
//   mem_rsp_valid/data/err            in-order fetch response, never back-pressured
//   inst_valid/ready/pc/data/err      queue head towards decode
interface ifu_prefetch_queue_if #(
  parameter int XLEN = 32
);
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [XLEN-1:0] mem_req_addr;
  logic            mem_rsp_valid;
  logic [XLEN-1:0] mem_rsp_data;
  logic            mem_rsp_err;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst_pc;
  logic [XLEN-1:0] inst_data;
  logic            inst_err;

  modport master (
    input  redirect_valid, redirect_pc,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err,
    input  inst_ready,
    output mem_req_valid, mem_req_addr,
    output inst_valid, inst_pc, inst_data, inst_err
  );

  modport slave (
    output redirect_valid, redirect_pc,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err,
    output inst_ready,
    input  mem_req_valid, mem_req_addr,
    input  inst_valid, inst_pc, inst_data, inst_err
  );
endinterface

// File: rtl/ifu_prefetch_queue.sv
// rtl/ifu_prefetch_queue.sv - instruction fetch unit with credit-limited prefetch queue
//
// Purpose: issues sequential word fetches, buffers in-order responses in a
// DEPTH-entry queue and presents the head to decode. A redirect flushes the
// queue and discards every response still in flight from the old path.
// Ports:
//   clk  core clock
//   rst  asynchronous active-high reset
//   bus  ifu_prefetch_queue_if.master (redirect, memory request/response, instruction output)
module ifu_prefetch_queue #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000,
  parameter int              DEPTH    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  ifu_prefetch_queue_if.master bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0]     DEPTH_W = (CW + 1)'(DEPTH);
  localparam logic [XLEN-1:0] STEP    = XLEN'(4);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [CW-1:0]   count;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop;
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;

  logic [DEPTH-1:0][XLEN-1:0] q_pc;
  logic [DEPTH-1:0][XLEN-1:0] q_data;
  logic [DEPTH-1:0]           q_err;

  logic [CW:0]     inflight;
  logic            fire;
  logic            pop;
  logic            rsp;
  logic            push;
  logic [CW-1:0]   out_after_rsp;
  logic [XLEN-1:0] redirect_aligned;

  // Buffered plus outstanding never exceeds DEPTH, so every response has a slot.
  assign inflight         = {1'b0, count} + {1'b0, outstanding};
  assign bus.mem_req_valid = !rst && !bus.redirect_valid && (inflight < DEPTH_W);
  assign bus.mem_req_addr  = fetch_pc;

  assign fire = bus.mem_req_valid && bus.mem_req_ready;
  assign pop  = bus.inst_valid && bus.inst_ready;
  assign rsp  = bus.mem_rsp_valid;
  // Responses belonging to a flushed path are swallowed while drop is non-zero.
  assign push = rsp && (drop == '0);

  assign out_after_rsp    = outstanding - CW'(rsp);
  assign redirect_aligned = bus.redirect_pc & ~XLEN'(3);

  assign bus.inst_valid = (count != '0);
  assign bus.inst_pc    = q_pc[head];
  assign bus.inst_data  = q_data[head];
  assign bus.inst_err   = q_err[head];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
      head        <= '0;
      tail        <= '0;
      q_pc        <= '0;
      q_data      <= '0;
      q_err       <= '0;
    end else if (bus.redirect_valid) begin
      // A pop in this cycle is already consumed; clearing the queue covers it.
      // Every fetch still in flight after this cycle belongs to the old path.
      fetch_pc    <= redirect_aligned;
      rsp_pc      <= redirect_aligned;
      count       <= '0;
      head        <= '0;
      tail        <= '0;
      outstanding <= out_after_rsp;
      drop        <= out_after_rsp;
    end else begin
      if (fire) begin
        fetch_pc <= fetch_pc + STEP;
      end
      outstanding <= outstanding + CW'(fire) - CW'(rsp);
      if (rsp && !push) begin
        drop <= drop - CW'(1);
      end
      if (push) begin
        q_pc[tail]   <= rsp_pc;
        q_data[tail] <= bus.mem_rsp_data;
        q_err[tail]  <= bus.mem_rsp_err;
        tail         <= tail + PW'(1);
        rsp_pc       <= rsp_pc + STEP;
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule
